// File: rtl/sdram_write_pg.sv
// SDRAM write engine: turns one burst request into ACT/WR/BST/PRE sequences.
// Bursts that cross a page boundary are split into one segment per row.
// The address advances linearly across columns, rows and banks.
// Per-beat byte masks travel with the data.
//
// Handshake: wr_ack is combinational and high in the cycle before each beat
// reaches the bus. In every cycle with wr_ack = 1 the source must present
// the word and its mask. The engine captures them at that rising edge, and
// they appear on wr_sdram_data / wr_sdram_dqm one cycle later with
// wr_sdram_en = 1. There is no back-pressure.
module sdram_write_pg #(
  parameter int DATA_W   = 16,
  parameter int BANK_W   = 2,
  parameter int ROW_W    = 13,
  parameter int COL_W    = 9,
  parameter int BLEN_W   = 10,
  parameter int TRCD_CYC = 2,
  parameter int TWR_CYC  = 2,
  parameter int TRP_CYC  = 2
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst_n,
  input  logic                            init_end,
  input  logic                            wr_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_addr,
  input  logic [BLEN_W-1:0]               wr_bst_len,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [DATA_W/8-1:0]             wr_mask,
  output logic                            wr_ack,
  output logic                            wr_end,
  output logic                            wr_busy,
  output logic [3:0]                      wr_sdram_cmd,
  output logic [BANK_W-1:0]               wr_sdram_bank,
  output logic [ROW_W-1:0]                wr_sdram_addr,
  output logic                            wr_sdram_en,
  output logic [DATA_W-1:0]               wr_sdram_data,
  output logic [DATA_W/8-1:0]             wr_sdram_dqm,
  output logic [3:0]                      dbg_state
);

  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int SEG_W  = (BLEN_W > COL_W + 1) ? BLEN_W : COL_W + 1;
  localparam int MSK_W  = DATA_W / 8;
  localparam int CNT_W  = 8;
  localparam int unsigned PAGE_WORDS = 2 ** COL_W;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_BST = 4'b0110;

  localparam logic [ROW_W-1:0] A10 = ROW_W'(1024);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_WR, S_DATA, S_BST, S_TWR, S_PRE, S_TRP, S_END
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cur_addr;
  logic [BLEN_W-1:0] remaining;
  logic [SEG_W-1:0]  seg_q;
  logic [SEG_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  cnt;

  logic [BANK_W-1:0] cur_bank;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;
  logic [SEG_W-1:0]  page_room;
  logic [SEG_W-1:0]  rem_ext;
  logic [SEG_W-1:0]  seg_comb;
  logic              accept;

  assign cur_bank = cur_addr[ADDR_W-1 -: BANK_W];
  assign cur_row  = cur_addr[COL_W +: ROW_W];
  assign cur_col  = cur_addr[COL_W-1:0];

  // Words left in the current row, computed one bit wider than the column.
  assign page_room = SEG_W'(PAGE_WORDS) - SEG_W'(cur_col);
  assign rem_ext   = SEG_W'(remaining);
  assign seg_comb  = (rem_ext < page_room) ? rem_ext : page_room;

  // A request is not taken during the wr_end cycle, so busy and acceptance agree.
  assign accept    = (state == S_IDLE) && init_end && wr_en && !wr_end;

  assign wr_ack    = (state == S_WR) || (state == S_DATA);
  assign wr_busy   = (state != S_IDLE) || wr_end;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (wr_bst_len == '0) ? S_END : S_ACT;
      S_ACT:  state_nxt = (TRCD_CYC > 1) ? S_TRCD : S_WR;
      S_TRCD: if (cnt == CNT_W'(TRCD_CYC - 2)) state_nxt = S_WR;
      S_WR:   state_nxt = (seg_q == SEG_W'(1)) ? S_BST : S_DATA;
      S_DATA: if (beat_cnt == seg_q - SEG_W'(1)) state_nxt = S_BST;
      S_BST:  state_nxt = (TWR_CYC > 1) ? S_TWR : S_PRE;
      S_TWR:  if (cnt == CNT_W'(TWR_CYC - 2)) state_nxt = S_PRE;
      S_PRE: begin
        if (TRP_CYC > 1) state_nxt = S_TRP;
        else state_nxt = (remaining != BLEN_W'(seg_q)) ? S_ACT : S_END;
      end
      S_TRP:  if (cnt == CNT_W'(TRP_CYC - 2))
                state_nxt = (remaining != '0) ? S_ACT : S_END;
      S_END:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address, length, segment and timing counters.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      seg_q     <= '0;
      beat_cnt  <= '0;
      cnt       <= '0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      if (accept) begin
        cur_addr  <= wr_addr;
        remaining <= wr_bst_len;
      end
      if (state == S_ACT) seg_q <= seg_comb;
      if (state == S_WR)   beat_cnt <= SEG_W'(1);
      if (state == S_DATA) beat_cnt <= beat_cnt + SEG_W'(1);
      // PRE still needs the old bank, so the address moves on only when PRE is left.
      if (state == S_PRE) begin
        cur_addr  <= cur_addr + ADDR_W'(seg_q);
        remaining <= remaining - BLEN_W'(seg_q);
      end
    end
  end

  // Registered SDRAM bus: each value reflects the state of the previous cycle.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= '1;
      wr_sdram_addr <= '1;
      wr_sdram_en   <= 1'b0;
      wr_sdram_data <= '0;
      wr_sdram_dqm  <= '0;
      wr_end        <= 1'b0;
    end else begin
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= '1;
      wr_sdram_addr <= '1;
      wr_sdram_en   <= wr_ack;
      wr_sdram_data <= wr_ack ? wr_data : '0;
      wr_sdram_dqm  <= wr_ack ? wr_mask : MSK_W'(0);
      wr_end        <= (state == S_END);
      case (state)
        S_ACT: begin
          wr_sdram_cmd  <= CMD_ACT;
          wr_sdram_bank <= cur_bank;
          wr_sdram_addr <= cur_row;
        end
        S_WR: begin
          wr_sdram_cmd  <= CMD_WR;
          wr_sdram_bank <= cur_bank;
          wr_sdram_addr <= ROW_W'(cur_col) & ~A10;
        end
        S_BST: wr_sdram_cmd <= CMD_BST;
        S_PRE: begin
          wr_sdram_cmd  <= CMD_PRE;
          wr_sdram_bank <= cur_bank;
          wr_sdram_addr <= A10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write_pg.sv
// Directed bench for sdram_write_pg with hand-computed cycle expectations.
module tb_sdram_write_pg;

  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, ACT = 4'b0011,
                         WRC = 4'b0100, BST = 4'b0110;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [1:0] bank;
    logic [12:0] addr;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [1:0]  dqm;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        wr_en = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [9:0]  wr_bst_len = '0;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic        wr_ack, wr_end, wr_busy, wr_sdram_en;
  logic [3:0]  wr_sdram_cmd, dbg_state;
  logic [1:0]  wr_sdram_bank, wr_sdram_dqm;
  logic [12:0] wr_sdram_addr;
  logic [15:0] wr_sdram_data;

  int cyc = 0;
  int ack_idx = 0;
  int base_idx = 0;
  int tag = 0;
  logic [1:0] mask_pat [4] = '{2'b00, 2'b00, 2'b00, 2'b00};

  cmd_t  cmd_log[$];
  beat_t beat_log[$];
  logic [15:0] exp_q[$];
  int cmd_base, beat_base;
  int n_vec = 0;
  int n_err = 0;

  sdram_write_pg dut (
    .wr_clk(clk), .wr_rst_n(rst_n), .init_end(init_end), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_bst_len(wr_bst_len), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_ack(wr_ack), .wr_end(wr_end), .wr_busy(wr_busy),
    .wr_sdram_cmd(wr_sdram_cmd), .wr_sdram_bank(wr_sdram_bank),
    .wr_sdram_addr(wr_sdram_addr), .wr_sdram_en(wr_sdram_en),
    .wr_sdram_data(wr_sdram_data), .wr_sdram_dqm(wr_sdram_dqm),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word source: word k of the current request is 0xA000 + tag*256 + k
  always @(posedge clk) if (wr_ack === 1'b1) ack_idx <= ack_idx + 1;
  assign wr_data = 16'(32'hA000 + tag * 256 + (ack_idx - base_idx));
  assign wr_mask = mask_pat[(ack_idx - base_idx) & 3];

  // Bus monitor
  always @(negedge clk) begin
    if (wr_sdram_cmd !== NOP)
      cmd_log.push_back('{cyc, wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr});
    if (wr_sdram_en === 1'b1)
      beat_log.push_back('{cyc, wr_sdram_data, wr_sdram_dqm});
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic req(input logic [23:0] addr, input int len, input int t_tag, output int c);
    @(negedge clk);
    tag = t_tag;
    base_idx = ack_idx;
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(16'(32'hA000 + t_tag * 256 + k));
    cmd_base  = cmd_log.size();
    beat_base = beat_log.size();
    wr_en = 1'b1;
    wr_addr = addr;
    wr_bst_len = 10'(len);
    c = cyc;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits for wr_end and returns its cycle (-1 on timeout), checking busy around it.
  task automatic wait_end(input string name, input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_end === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    check({name, " busy_at_end"}, 32'(wr_busy), 1);
    @(negedge clk);
    check({name, " busy_after_end"}, 32'(wr_busy), 0);
  endtask

  task automatic chk_cmd(input string name, input int i, input int c_exp, input logic [3:0] cmd,
                         input logic [1:0] bank, input logic [12:0] addr, input bit chk_ba);
    int idx;
    idx = cmd_base + i;
    check($sformatf("%s cmd%0d present", name, i), 32'(cmd_log.size() > idx), 1);
    if (cmd_log.size() > idx) begin
      check($sformatf("%s cmd%0d cyc", name, i), 32'(cmd_log[idx].cyc), 32'(c_exp));
      check($sformatf("%s cmd%0d code", name, i), 32'(cmd_log[idx].cmd), 32'(cmd));
      if (chk_ba) begin
        check($sformatf("%s cmd%0d bank", name, i), 32'(cmd_log[idx].bank), 32'(bank));
        check($sformatf("%s cmd%0d addr", name, i), 32'(cmd_log[idx].addr), 32'(addr));
      end
    end
  endtask

  task automatic chk_beat(input string name, input int i, input int c_exp, input logic [1:0] dqm);
    int idx;
    logic [15:0] exp_d;
    idx = beat_base + i;
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
    check($sformatf("%s beat%0d present", name, i), 32'(beat_log.size() > idx), 1);
    if (beat_log.size() > idx) begin
      check($sformatf("%s beat%0d cyc", name, i), 32'(beat_log[idx].cyc), 32'(c_exp));
      check($sformatf("%s beat%0d data", name, i), 32'(beat_log[idx].data), 32'(exp_d));
      check($sformatf("%s beat%0d dqm", name, i), 32'(beat_log[idx].dqm), 32'(dqm));
    end
  endtask

  task automatic chk_counts(input string name, input int n_cmd, input int n_beat, input int n_ack);
    check({name, " n_cmd"}, 32'(cmd_log.size() - cmd_base), 32'(n_cmd));
    check({name, " n_beat"}, 32'(beat_log.size() - beat_base), 32'(n_beat));
    check({name, " n_ack"}, 32'(ack_idx - base_idx), 32'(n_ack));
  endtask

  task automatic chk_idle(input string name);
    check({name, " cmd"}, 32'(wr_sdram_cmd), 32'(NOP));
    check({name, " bank"}, 32'(wr_sdram_bank), 32'h3);
    check({name, " addr"}, 32'(wr_sdram_addr), 32'h1FFF);
    check({name, " en"}, 32'(wr_sdram_en), 0);
    check({name, " data"}, 32'(wr_sdram_data), 0);
    check({name, " dqm"}, 32'(wr_sdram_dqm), 0);
    check({name, " end"}, 32'(wr_end), 0);
    check({name, " busy"}, 32'(wr_busy), 0);
    check({name, " ack"}, 32'(wr_ack), 0);
  endtask

  initial begin
    int c, t, e;
    // Reset
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    init_end = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("post_reset");

    // Single burst: {1,5,0}, 4 words
    req({2'd1, 13'd5, 9'd0}, 4, 1, c);
    t = c + 2;
    wait_end("single", 40, e);
    check("single end_cyc", 32'(e), 32'(t + 10));
    chk_counts("single", 4, 4, 4);
    chk_cmd("single", 0, t,     ACT, 2'd1, 13'd5,     1);
    chk_cmd("single", 1, t + 2, WRC, 2'd1, 13'd0,     1);
    chk_cmd("single", 2, t + 6, BST, 2'd0, 13'd0,     0);
    chk_cmd("single", 3, t + 8, PRE, 2'd1, 13'h0400,  1);
    for (int k = 0; k < 4; k++) chk_beat("single", k, t + 2 + k, 2'b00);

    // Page split: {0,7,510}, 4 words -> 2 beats in row 7, 2 beats in row 8
    req({2'd0, 13'd7, 9'd510}, 4, 2, c);
    t = c + 2;
    wait_end("split", 60, e);
    check("split end_cyc", 32'(e), 32'(t + 16));
    chk_counts("split", 8, 4, 4);
    chk_cmd("split", 0, t,      ACT, 2'd0, 13'd7,    1);
    chk_cmd("split", 1, t + 2,  WRC, 2'd0, 13'd510,  1);
    chk_cmd("split", 2, t + 4,  BST, 2'd0, 13'd0,    0);
    chk_cmd("split", 3, t + 6,  PRE, 2'd0, 13'h0400, 1);
    chk_cmd("split", 4, t + 8,  ACT, 2'd0, 13'd8,    1);
    chk_cmd("split", 5, t + 10, WRC, 2'd0, 13'd0,    1);
    chk_cmd("split", 6, t + 12, BST, 2'd0, 13'd0,    0);
    chk_cmd("split", 7, t + 14, PRE, 2'd0, 13'h0400, 1);
    chk_beat("split", 0, t + 2,  2'b00);
    chk_beat("split", 1, t + 3,  2'b00);
    chk_beat("split", 2, t + 10, 2'b00);
    chk_beat("split", 3, t + 11, 2'b00);

    // Mask pattern 01, 10, 00, 11
    mask_pat = '{2'b01, 2'b10, 2'b00, 2'b11};
    req({2'd2, 13'd3, 9'd4}, 4, 3, c);
    t = c + 2;
    wait_end("mask", 40, e);
    check("mask end_cyc", 32'(e), 32'(t + 10));
    chk_beat("mask", 0, t + 2, 2'b01);
    chk_beat("mask", 1, t + 3, 2'b10);
    chk_beat("mask", 2, t + 4, 2'b00);
    chk_beat("mask", 3, t + 5, 2'b11);
    mask_pat = '{2'b00, 2'b00, 2'b00, 2'b00};

    // Gating: no initialisation done -> nothing happens
    init_end = 1'b0;
    req({2'd1, 13'd1, 9'd1}, 3, 4, c);
    repeat (20) @(negedge clk);
    chk_counts("no_init", 0, 0, 0);
    check("no_init busy", 32'(wr_busy), 0);
    init_end = 1'b1;

    // Gating: a second wr_en while busy is ignored
    req({2'd1, 13'd2, 9'd3}, 2, 5, c);
    t = c + 2;
    repeat (2) @(negedge clk);
    wr_en = 1'b1;
    wr_addr = {2'd2, 13'd0, 9'd0};
    wr_bst_len = 10'd4;
    @(negedge clk);
    wr_en = 1'b0;
    wait_end("busy_ign", 40, e);
    check("busy_ign end_cyc", 32'(e), 32'(t + 8));
    repeat (5) @(negedge clk);
    chk_counts("busy_ign", 4, 2, 2);
    chk_cmd("busy_ign", 0, t,     ACT, 2'd1, 13'd2,    1);
    chk_cmd("busy_ign", 1, t + 2, WRC, 2'd1, 13'd3,    1);
    chk_cmd("busy_ign", 2, t + 4, BST, 2'd0, 13'd0,    0);
    chk_cmd("busy_ign", 3, t + 6, PRE, 2'd1, 13'h0400, 1);

    // Zero length: wr_end only
    req({2'd3, 13'd9, 9'd9}, 0, 6, c);
    wait_end("len0", 20, e);
    check("len0 end_cyc", 32'(e), 32'(c + 2));
    chk_counts("len0", 0, 0, 0);

    // Wrap from all-ones to zero
    req(24'hFFFFFF, 2, 7, c);
    t = c + 2;
    wait_end("wrap", 60, e);
    check("wrap end_cyc", 32'(e), 32'(t + 14));
    chk_counts("wrap", 8, 2, 2);
    chk_cmd("wrap", 0, t,      ACT, 2'd3, 13'h1FFF, 1);
    chk_cmd("wrap", 1, t + 2,  WRC, 2'd3, 13'd511,  1);
    chk_cmd("wrap", 2, t + 3,  BST, 2'd0, 13'd0,    0);
    chk_cmd("wrap", 3, t + 5,  PRE, 2'd3, 13'h0400, 1);
    chk_cmd("wrap", 4, t + 7,  ACT, 2'd0, 13'd0,    1);
    chk_cmd("wrap", 5, t + 9,  WRC, 2'd0, 13'd0,    1);
    chk_cmd("wrap", 6, t + 10, BST, 2'd0, 13'd0,    0);
    chk_cmd("wrap", 7, t + 12, PRE, 2'd0, 13'h0400, 1);
    chk_beat("wrap", 0, t + 2, 2'b00);
    chk_beat("wrap", 1, t + 9, 2'b00);

    // Mid-burst reset, then a fresh request
    req({2'd0, 13'd1, 9'd0}, 8, 8, c);
    t = c + 2;
    while (cyc < t + 4) @(negedge clk);
    check("midrst en_before", 32'(wr_sdram_en), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("midrst_after");
    req({2'd2, 13'd9, 9'd100}, 1, 9, c);
    t = c + 2;
    wait_end("fresh", 40, e);
    check("fresh end_cyc", 32'(e), 32'(t + 7));
    chk_counts("fresh", 4, 1, 1);
    chk_cmd("fresh", 0, t,     ACT, 2'd2, 13'd9,    1);
    chk_cmd("fresh", 1, t + 2, WRC, 2'd2, 13'd100,  1);
    chk_cmd("fresh", 2, t + 3, BST, 2'd0, 13'd0,    0);
    chk_cmd("fresh", 3, t + 5, PRE, 2'd2, 13'h0400, 1);
    chk_beat("fresh", 0, t + 2, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_write_pg.md
# sdram_write_pg

Parametrised SDRAM write engine for the controller's arbitration path. It takes one burst request of up to 2^BLEN_W−1 words and issues the ACT / WR / BST / PRE command sequence, honouring tRCD, tWR and tRP. It adds three things: per-beat byte masks, automatic splitting of bursts that cross a page (row) boundary, and linear address wrap across rows and banks. Its outputs feed the command arbiter next to the init, refresh and read engines.

## Interface
- DATA_W, 16, data width; must be a multiple of 8
- BANK_W, 2, bank address bits
- ROW_W, 13, row address bits; must be ≥ 11
- COL_W, 9, column bits; page = 2^COL_W words
- BLEN_W, 10, burst-length field width
- TRCD_CYC, 2, cycles from ACT on the bus to WR on the bus; ≥ 1
- TWR_CYC, 2, cycles from last data beat to PRE is TWR_CYC+1; ≥ 1
- TRP_CYC, 2, cycles from PRE to the next ACT or to wr_end; ≥ 1
- wr_clk, in, 1, clock; all logic on its rising edge
- wr_rst_n, in, 1, reset; synchronous, active-low
- init_end, in, 1, SDRAM initialisation done
- wr_en, in, 1, request; sampled only in IDLE
- wr_addr, in, BANK_W+ROW_W+COL_W, start address {bank,row,col}
- wr_bst_len, in, BLEN_W, number of words
- wr_data, in, DATA_W, write word
- wr_mask, in, DATA_W/8, byte mask; 1 = byte not written
- wr_ack, out, 1, word accept strobe
- wr_end, out, 1, one-cycle completion pulse
- wr_busy, out, 1, high whenever state ≠ IDLE
- wr_sdram_cmd, out, 4, {CS#,RAS#,CAS#,WE#}
- wr_sdram_bank, out, BANK_W, bank address
- wr_sdram_addr, out, ROW_W, address bus
- wr_sdram_en, out, 1, this engine is driving valid data
- wr_sdram_data, out, DATA_W, data to the DQ bus
- wr_sdram_dqm, out, DATA_W/8, DQM to the DQM pins

## Operation
- Command codes: NOP 0111, PRE 0010, ACT 0011, WR 0100, BST 0110.
- States: IDLE, ACT, TRCD, WR, DATA, BST, TWR, PRE, TRP, END.
- Every sdram output is registered from the current state, so each output appears one cycle after its state.
- Idle bus values: cmd NOP, bank all-ones, addr all-ones, en 0, data 0, dqm 0.
- IDLE:
  - Advances when init_end && wr_en.
  - Latches wr_addr into the current address (cur_addr) and wr_bst_len into the remaining-word count (remaining).
  - If wr_bst_len = 0, goes straight to END and issues no commands.
- Segment length is seg = min(remaining, 2^COL_W − col). This needs COL_W+1-bit arithmetic.
- ACT: bank = cur bank; addr = row.
- TRCD: NOP until TRCD_CYC has elapsed.
- WR: bank = cur bank; addr = col, zero-extended, with A10 = 0.
- DATA: beats follow WR back-to-back on consecutive cycles, seg beats in total.
- BST: issued on the cycle after the last beat, then NOP until TWR_CYC has elapsed.
- PRE: bank = cur bank; addr = A10 only (0x0400 for ROW_W = 13). Then TRP.
- Address update: after each segment, cur_addr += seg as one linear {bank,row,col} number, wrapping from all-ones to 0. remaining −= seg.
- After TRP: goes to ACT if remaining > 0 (page split), otherwise to END.
- END: wr_end is high for exactly one cycle, then the engine returns to IDLE.
- wr_ack rule: wr_ack is combinational. It is high in the cycle before each beat appears on the bus.
- Data capture: in a cycle with wr_ack = 1, wr_data and wr_mask are captured and appear on wr_sdram_data / wr_sdram_dqm in the next cycle with wr_sdram_en = 1.
- wr_ack count: exactly wr_bst_len acks per request.
- wr_en and wr_addr are ignored while busy.
- Reset: wr_rst_n low at an edge forces state IDLE, all outputs to their idle values, wr_end = 0 and the counters to 0. This applies mid-burst as well; the aborted burst is not resumed.

## Timing
- wr_en sampled at cycle c: ACT is on the bus at c+2 (call this t).
- WR with the first beat is on the bus at t+TRCD_CYC; the first wr_ack is at t+TRCD_CYC−1.
- If the last beat of a segment is on the bus at u:
  - BST at u+1
  - PRE at u+TWR_CYC+1
  - next ACT, or wr_end, at u+TWR_CYC+1+TRP_CYC
- wr_en sampled at c with length 0: wr_end at c+2, no commands issued.
- wr_busy rises at c+1 and falls in the cycle after wr_end.

## Test plan
- **Single burst.** Default parameters, addr {1,5,0}, len 4, ACT at t.
  - Expect WR (bank 1, col 0) with D0 at t+2, then D1–D3 at t+3..t+5.
  - BST at t+6, PRE (bank 1, 0x0400) at t+8, wr_end at t+10, exactly 4 acks.
- **Page split.** col 510, row 7, len 4.
  - Expect 2 beats at row 7, then BST/PRE.
  - Then ACT row 8, WR col 0, 2 beats; one wr_end; 4 acks total.
- **Mask.** Mask pattern 01, 10, 00, 11 over a 4-word burst.
  - wr_sdram_dqm must follow the same pattern, aligned beat-for-beat with the data.
- **Gating.**
  - wr_en with init_end = 0 → no commands.
  - wr_en while busy → ignored.
  - len 0 → wr_end pulse only, no command other than NOP.
- **Wrap.** addr all-ones, len 2.
  - Beat 1 at bank 3, row 0x1FFF, col 511.
  - Beat 2 at bank 0, row 0, col 0, after PRE/ACT.
- **Mid-burst reset.** Reset asserted during DATA.
  - All outputs take idle values at the next edge.
  - A fresh request then completes normally.
